// File: rtl/dlx_mem_responder.sv
// dlx_mem_responder
//   Memory-side responder for the DLX bus. Captures an AS_N-strobed
//   read/write request, waits WAIT_STATES cycles, then serves it from an
//   internal word-addressed RAM and answers with a one-cycle ACK_N pulse.
//
// Parameters
//   DEPTH_LOG2  : log2 of RAM depth in 32-bit words
//   WAIT_STATES : wait cycles between capture and ACK (0..15)
//
// Ports
//   CLK     : system clock, rising edge
//   RESET   : asynchronous active-high reset
//   AS_N    : address strobe, active low, held for the whole transaction
//   WR_N    : 0 = write, 1 = read (sampled with AS_N)
//   ADDR    : physical word address
//   DI      : write data (sampled with AS_N)
//   DO      : registered read data, valid while ACK_N = 0
//   ACK_N   : one-cycle active-low transfer acknowledge
//   BUS_ERR : registered out-of-range flag, asserted with ACK_N
//
// Optional feature
//   DLX_MEM_RANGE_CHECK_EN : when defined, addresses with any bit set in
//   ADDR[31:DEPTH_LOG2] complete with BUS_ERR = 1, DO = 0 and no RAM write.
//   When undefined, upper address bits are ignored (addresses alias) and
//   BUS_ERR is tied to 0.
module dlx_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AS_N,
  input  logic        WR_N,
  input  logic [31:0] ADDR,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        ACK_N,
  output logic        BUS_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   addr_lat;
  logic                    is_wr;
  logic [31:0]             di_lat;
  logic [31:0]             do_q;
  logic                    ack_n_q;
  logic                    enter_ack;
  logic                    acc_err;

  logic [31:0] mem [2**DEPTH_LOG2];

  // The request is always captured into WAIT, even with zero wait states;
  // WAIT then runs WAIT_STATES+1 cycles, so ACK_N goes low in the cycle
  // after edge N+WAIT_STATES+1 when AS_N was captured at edge N.
  assign enter_ack = (state == S_WAIT) && !AS_N && (cnt == '0);

`ifdef DLX_MEM_RANGE_CHECK_EN
  logic range_err;
  logic err_lat;
  logic bus_err_q;

  assign range_err = (ADDR >> DEPTH_LOG2) != '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_lat   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && !AS_N)
        err_lat <= range_err;
      // High only for the ACK cycle; drops again on leaving ACK.
      bus_err_q <= enter_ack && err_lat;
    end
  end

  assign acc_err = err_lat;
  assign BUS_ERR = bus_err_q;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^ADDR[31:DEPTH_LOG2];
  assign acc_err        = 1'b0;
  assign BUS_ERR        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_lat <= '0;
      is_wr    <= 1'b0;
      di_lat   <= '0;
      do_q     <= '0;
      ack_n_q  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!AS_N) begin
            addr_lat <= ADDR[DEPTH_LOG2-1:0];
            is_wr    <= !WR_N;
            di_lat   <= DI;
            cnt      <= 4'(WAIT_STATES);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (AS_N) begin
            // Initiator withdrew the strobe: drop the request silently.
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == '0) begin
            ack_n_q <= 1'b0;
            state   <= S_ACK;
            if (acc_err)
              do_q <= '0;
            else if (!is_wr)
              do_q <= mem[addr_lat];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          ack_n_q <= 1'b1;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          if (AS_N)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; contents survive RESET.
  always_ff @(posedge CLK) begin
    if (enter_ack && is_wr && !acc_err)
      mem[addr_lat] <= di_lat;
  end

  assign DO    = do_q;
  assign ACK_N = ack_n_q;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Self-checking bench for dlx_mem_responder: three instances with
// WAIT_STATES = 2, 0 and 4, table-driven vectors, hand-written corner
// sequences (hold after ACK, abort in WAIT, reset in WAIT, range check)
// and a randomized phase against a behavioural memory model.
module tb_dlx_mem_responder;

`ifdef DLX_MEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  as_n;
  logic [2:0]  wr_n;
  logic [31:0] addr [3];
  logic [31:0] di   [3];
  logic [31:0] dout [3];
  logic [2:0]  ack_n;
  logic [2:0]  berr;

  int          n_cmp;
  int          n_bad;
  logic [31:0] mdl [3][1024];
  logic [31:0] last_do [3];
  int          ws_of [3];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_do;
    bit          exp_err;
  } vec_t;

  vec_t tbl [8];

  dlx_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
    .CLK(clk), .RESET(rst[0]), .AS_N(as_n[0]), .WR_N(wr_n[0]),
    .ADDR(addr[0]), .DI(di[0]), .DO(dout[0]), .ACK_N(ack_n[0]),
    .BUS_ERR(berr[0]));

  dlx_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RESET(rst[1]), .AS_N(as_n[1]), .WR_N(wr_n[1]),
    .ADDR(addr[1]), .DI(di[1]), .DO(dout[1]), .ACK_N(ack_n[1]),
    .BUS_ERR(berr[1]));

  dlx_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(4)) u_ws4 (
    .CLK(clk), .RESET(rst[2]), .AS_N(as_n[2]), .WR_N(wr_n[2]),
    .ADDR(addr[2]), .DI(di[2]), .DO(dout[2]), .ACK_N(ack_n[2]),
    .BUS_ERR(berr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // One full transaction on instance k; AS_N held 'hold' extra cycles after ACK.
  task automatic xact(input int k, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_do,
                      input bit exp_err, input int hold);
    int c;
    bit got;
    @(negedge clk);
    as_n[k] = 1'b0;
    wr_n[k] = !wr;
    addr[k] = a;
    di[k]   = d;
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (ack_n[k] == 1'b0) got = 1'b1;
    end
    chk($sformatf("latency[%0d] a=%h", k, a), c, ws_of[k] + 2);
    if (got) begin
      chk($sformatf("do[%0d] a=%h", k, a), dout[k], exp_do);
      chk($sformatf("bus_err[%0d] a=%h", k, a), {31'b0, berr[k]}, {31'b0, exp_err});
    end
    @(negedge clk);
    chk($sformatf("ack_width[%0d]", k), {31'b0, ack_n[k]}, 32'd1);
    chk($sformatf("err_drop[%0d]", k), {31'b0, berr[k]}, 32'd0);
    chk($sformatf("do_hold[%0d]", k), dout[k], exp_do);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("no_reack[%0d] cyc%0d", k, i), {31'b0, ack_n[k]}, 32'd1);
    end
    as_n[k] = 1'b1;
    if (wr && !exp_err) mdl[k][a[9:0]] = d;
    last_do[k] = exp_do;
  endtask

  // Model-derived expectations for a random access.
  task automatic rand_xact(input int k);
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          err;
    logic [31:0] e;
    wr = $urandom_range(0, 1) == 1;
    a  = 32'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = a + (32'($urandom_range(1, 255)) << 10);
    d   = $urandom;
    err = RANGE_EN && ((a >> 10) != 0);
    if (err)     e = 32'h0;
    else if (wr) e = last_do[k];
    else         e = mdl[k][a[9:0]];
    xact(k, wr, a, d, e, err, $urandom_range(0, 2));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ws_of[0] = 2; ws_of[1] = 0; ws_of[2] = 4;
    rst  = '1;
    as_n = '1;
    wr_n = '1;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0;
      di[k]   = '0;
      last_do[k] = '0;
      for (int j = 0; j < 1024; j++) mdl[k][j] = '0;
    end

    tbl[0] = '{wr: 1'b1, a: 32'h10,  d: 32'hDEADBEEF, exp_do: 32'h0,        exp_err: 1'b0};
    tbl[1] = '{wr: 1'b0, a: 32'h10,  d: 32'h0,        exp_do: 32'hDEADBEEF, exp_err: 1'b0};
    tbl[2] = '{wr: 1'b1, a: 32'h20,  d: 32'h0,        exp_do: 32'hDEADBEEF, exp_err: 1'b0};
    tbl[3] = '{wr: 1'b1, a: 32'h0,   d: 32'h0,        exp_do: 32'hDEADBEEF, exp_err: 1'b0};
    tbl[4] = '{wr: 1'b1, a: 32'h3FF, d: 32'hCAFEF00D, exp_do: 32'hDEADBEEF, exp_err: 1'b0};
    tbl[5] = '{wr: 1'b0, a: 32'h3FF, d: 32'h0,        exp_do: 32'hCAFEF00D, exp_err: 1'b0};
    tbl[6] = '{wr: 1'b0, a: 32'h20,  d: 32'h0,        exp_do: 32'h0,        exp_err: 1'b0};
    tbl[7] = '{wr: 1'b0, a: 32'h0,   d: 32'h0,        exp_do: 32'h0,        exp_err: 1'b0};

    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ack[%0d]", k), {31'b0, ack_n[k]}, 32'd1);
      chk($sformatf("rst_do[%0d]", k), dout[k], 32'h0);
      chk($sformatf("rst_err[%0d]", k), {31'b0, berr[k]}, 32'd0);
    end

    for (int i = 0; i < 8; i++)
      xact(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp_do, tbl[i].exp_err, 0);

    // Strobe held 10 cycles after ACK, then a fresh read after release.
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 10);
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Abort during WAIT: no ACK, no write.
    @(negedge clk);
    as_n[0] = 1'b0; wr_n[0] = 1'b0; addr[0] = 32'h20; di[0] = 32'h12345678;
    @(negedge clk);
    chk("abort_noack0", {31'b0, ack_n[0]}, 32'd1);
    as_n[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_noack%0d", i + 1), {31'b0, ack_n[0]}, 32'd1);
    end
    xact(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0);

    // Range check / aliasing.
    xact(0, 1'b1, 32'h4, 32'h44444444, last_do[0], 1'b0, 0);
    xact(0, 1'b0, 32'h01000004, 32'h0, RANGE_EN ? 32'h0 : 32'h44444444, RANGE_EN, 0);
    xact(0, 1'b1, 32'h400, 32'h11111111, RANGE_EN ? 32'h0 : 32'h44444444, RANGE_EN, 0);
    xact(0, 1'b0, 32'h0, 32'h0, RANGE_EN ? 32'h0 : 32'h11111111, 1'b0, 0);

    // Zero wait states.
    xact(1, 1'b1, 32'h5, 32'h55AA55AA, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h5, 32'h0, 32'h55AA55AA, 1'b0, 1);

    // Reset in the middle of WAIT with four wait states.
    xact(2, 1'b1, 32'h8, 32'h88888888, 32'h0, 1'b0, 0);
    xact(2, 1'b0, 32'h8, 32'h0, 32'h88888888, 1'b0, 0);
    @(negedge clk);
    as_n[2] = 1'b0; wr_n[2] = 1'b0; addr[2] = 32'h8; di[2] = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ws4_wait%0d", i), {31'b0, ack_n[2]}, 32'd1);
    end
    #2 rst[2] = 1'b1;
    #1;
    chk("midrst_ack", {31'b0, ack_n[2]}, 32'd1);
    chk("midrst_do", dout[2], 32'h0);
    chk("midrst_err", {31'b0, berr[2]}, 32'd0);
    @(negedge clk);
    rst[2]  = 1'b0;
    as_n[2] = 1'b1;
    last_do[2] = 32'h0;
    xact(2, 1'b0, 32'h8, 32'h0, 32'h88888888, 1'b0, 0);

    // Randomized phase against the memory model.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin
        logic [31:0] v;
        v = $urandom;
        xact(k, 1'b1, 32'(j), v, last_do[k], 1'b0, 0);
      end
      for (int n = 0; n < 40; n++) rand_xact(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
